// File: rtl/freq_div_sequencer.sv
// ---------------------------------------------------------------------------
// freq_div_sequencer
//   Start/stop controller for a power-of-two frequency divider. A run is
//   started with START, which latches the period exponent (DIV_SEL) and the
//   burst length (NCYC). The output is low for the first half of each period
//   and high for the second half. A STOP request takes effect only on a
//   period boundary, so OUT always finishes low after a complete period.
//
// Ports
//   CLOCK    in   1       system clock, rising edge
//   RESET    in   1       synchronous active-high reset
//   START    in   1       level; starts a run when idle
//   STOP     in   1       level; ends the run at the end of the current period
//   DIV_SEL  in   5       period exponent k (period = 2^k clocks), 0 -> 1,
//                         values above CNT_W clamp to CNT_W
//   NCYC     in   NCYC_W  periods per burst, 0 = run until stopped
//   OUT      out  1       divided output
//   BUSY     out  1       high while a run is active
//   DONE     out  1       one-clock pulse after a run returns to idle
//   CYC_CNT  out  NCYC_W  completed periods in the current/last run
// ---------------------------------------------------------------------------
module freq_div_sequencer #(
  parameter int CNT_W  = 20,
  parameter int NCYC_W = 8
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              START,
  input  logic              STOP,
  input  logic [4:0]        DIV_SEL,
  input  logic [NCYC_W-1:0] NCYC,
  output logic              OUT,
  output logic              BUSY,
  output logic              DONE,
  output logic [NCYC_W-1:0] CYC_CNT
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_t;

  localparam logic [4:0] K_MAX = 5'(CNT_W);

  state_t            r_state;
  logic [4:0]        r_k;
  logic [NCYC_W-1:0] r_ncyc;
  logic [NCYC_W-1:0] r_cyc_cnt;
  logic [CNT_W-1:0]  r_count;
  logic              r_done;

  logic [CNT_W-1:0]  w_term_mask;
  logic [CNT_W-1:0]  w_half_mask;
  logic [4:0]        w_k_in;
  logic [NCYC_W-1:0] w_cyc_inc;
  logic              w_terminal;
  logic              w_burst_end;

  // Period exponent is normalised once at start so the datapath only ever
  // sees 1..CNT_W.
  assign w_k_in = (DIV_SEL == 5'd0)   ? 5'd1  :
                  (DIV_SEL > K_MAX)   ? K_MAX : DIV_SEL;

  // w_term_mask = 2^k - 1 (terminal count); w_half_mask selects bit k-1,
  // which is the high half of the period.
  genvar gi;
  generate
    for (gi = 0; gi < CNT_W; gi++) begin : g_mask
      assign w_term_mask[gi] = (5'(gi) < r_k);
      assign w_half_mask[gi] = (5'(gi + 1) == r_k);
    end
  endgenerate

  assign w_terminal  = (r_count == w_term_mask);
  assign w_cyc_inc   = r_cyc_cnt + NCYC_W'(1);
  assign w_burst_end = (r_ncyc != '0) && (w_cyc_inc == r_ncyc);

  assign BUSY    = (r_state != ST_IDLE);
  assign OUT     = BUSY & (|(r_count & w_half_mask));
  assign DONE    = r_done;
  assign CYC_CNT = r_cyc_cnt;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state   <= ST_IDLE;
      r_k       <= 5'd1;
      r_ncyc    <= '0;
      r_cyc_cnt <= '0;
      r_count   <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // STOP is deliberately not looked at here.
          if (START) begin
            r_k       <= w_k_in;
            r_ncyc    <= NCYC;
            r_count   <= '0;
            r_cyc_cnt <= '0;
            r_state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_terminal) begin
            r_count   <= '0;
            r_cyc_cnt <= w_cyc_inc;
            // A STOP seen on the terminal edge ends the run immediately
            // rather than starting another period.
            if (w_burst_end || STOP) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end
          end else begin
            r_count <= r_count + CNT_W'(1);
            if (STOP) begin
              r_state <= ST_STOPPING;
            end
          end
        end
        ST_STOPPING: begin
          if (w_terminal) begin
            r_count   <= '0;
            r_cyc_cnt <= w_cyc_inc;
            r_state   <= ST_IDLE;
            r_done    <= 1'b1;
          end else begin
            r_count <= r_count + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_div_sequencer.sv
// ---------------------------------------------------------------------------
// tb_freq_div_sequencer
//   Self-checking bench. The reference model tracks elapsed clocks since the
//   accepted START and derives phase, output and completed periods from
//   plain arithmetic on that time. A short CNT_W keeps the clamped maximum
//   period small enough to run completely.
// ---------------------------------------------------------------------------
module tb_freq_div_sequencer;

  localparam int CNT_W  = 12;
  localparam int NCYC_W = 8;

  logic              CLOCK = 1'b0;
  logic              RESET = 1'b1;
  logic              START = 1'b0;
  logic              STOP  = 1'b0;
  logic [4:0]        DIV_SEL = 5'd0;
  logic [NCYC_W-1:0] NCYC = '0;
  logic              OUT;
  logic              BUSY;
  logic              DONE;
  logic [NCYC_W-1:0] CYC_CNT;

  always #5 CLOCK = ~CLOCK;

  freq_div_sequencer #(.CNT_W(CNT_W), .NCYC_W(NCYC_W)) dut (
    .CLOCK   (CLOCK),
    .RESET   (RESET),
    .START   (START),
    .STOP    (STOP),
    .DIV_SEL (DIV_SEL),
    .NCYC    (NCYC),
    .OUT     (OUT),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .CYC_CNT (CYC_CNT)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: elapsed time t since the accepted START, period p.
  bit     m_busy     = 0;
  bit     m_done     = 0;
  bit     m_stop_req = 0;
  longint m_t        = 0;
  longint m_p        = 2;
  longint m_ncyc     = 0;
  int     m_cyc      = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic bit exp_out();
    return m_busy && ((m_t % m_p) >= (m_p / 2));
  endfunction

  task automatic model_edge(input bit rst, input bit st, input bit sp,
                            input logic [4:0] div, input logic [7:0] nc);
    int kk;
    if (rst) begin
      m_busy = 0; m_done = 0; m_stop_req = 0; m_t = 0; m_cyc = 0;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (st) begin
          kk = (div == 0) ? 1 : ((int'(div) > CNT_W) ? CNT_W : int'(div));
          m_p = longint'(1) << kk;
          m_ncyc = longint'(nc);
          m_t = 0; m_cyc = 0; m_stop_req = 0; m_busy = 1;
        end
      end else begin
        if (sp) m_stop_req = 1;
        m_t++;
        if ((m_t % m_p) == 0) begin
          m_cyc = int'((m_t / m_p) % 256);
          if (m_stop_req || (m_ncyc != 0 && (m_t / m_p) == m_ncyc)) begin
            m_busy = 0;
            m_done = 1;
          end
        end
      end
    end
  endtask

  // One clock: drive inputs, clock, advance model, compare after the edge.
  task automatic step(input bit rst, input bit st, input bit sp,
                      input logic [4:0] div, input logic [7:0] nc);
    RESET = rst; START = st; STOP = sp; DIV_SEL = div; NCYC = nc;
    @(posedge CLOCK);
    model_edge(rst, st, sp, div, nc);
    #1;
    check("model_out",  64'(OUT),     64'(exp_out()));
    check("model_busy", 64'(BUSY),    64'(m_busy));
    check("model_done", 64'(DONE),    64'(m_done));
    check("model_cyc",  64'(CYC_CNT), 64'(m_cyc));
  endtask

  typedef struct {
    bit         rst;
    bit         st;
    bit         sp;
    logic [4:0] div;
    logic [7:0] nc;
    bit         e_out;
    bit         e_busy;
    bit         e_done;
    int         e_cyc;
  } vec_t;

  vec_t tbl[26];

  bit out_h[0:4200];
  bit done_h[0:4200];
  bit busy_h[0:4200];
  int end_at;
  int done_cnt;

  initial begin
    // rst st sp div nc | out busy done cyc
    tbl[0]  = '{1, 0, 0, 5'd0, 8'd0, 0, 0, 0, 0};  // reset
    tbl[1]  = '{0, 1, 0, 5'd0, 8'd3, 0, 1, 0, 0};  // DIV_SEL 0 -> period 2, 3 periods
    tbl[2]  = '{0, 0, 0, 5'd0, 8'd0, 1, 1, 0, 0};
    tbl[3]  = '{0, 0, 0, 5'd0, 8'd0, 0, 1, 0, 1};
    tbl[4]  = '{0, 0, 0, 5'd0, 8'd0, 1, 1, 0, 1};
    tbl[5]  = '{0, 0, 0, 5'd0, 8'd0, 0, 1, 0, 2};
    tbl[6]  = '{0, 1, 0, 5'd5, 8'd0, 1, 1, 0, 2};  // START while busy ignored
    tbl[7]  = '{0, 0, 0, 5'd0, 8'd0, 0, 0, 1, 3};  // burst complete
    tbl[8]  = '{0, 0, 0, 5'd0, 8'd0, 0, 0, 0, 3};  // CYC_CNT held
    tbl[9]  = '{0, 0, 1, 5'd0, 8'd0, 0, 0, 0, 3};  // STOP in idle ignored
    tbl[10] = '{0, 1, 1, 5'd1, 8'd0, 0, 1, 0, 0};  // START+STOP: START wins
    tbl[11] = '{0, 0, 1, 5'd0, 8'd0, 1, 1, 0, 0};  // STOP mid-period
    tbl[12] = '{0, 0, 0, 5'd0, 8'd0, 0, 0, 1, 1};  // ends at period boundary
    tbl[13] = '{0, 1, 0, 5'd2, 8'd0, 0, 1, 0, 0};  // START in DONE cycle
    tbl[14] = '{0, 0, 0, 5'd0, 8'd0, 0, 1, 0, 0};
    tbl[15] = '{0, 0, 0, 5'd0, 8'd0, 1, 1, 0, 0};
    tbl[16] = '{0, 0, 0, 5'd0, 8'd0, 1, 1, 0, 0};
    tbl[17] = '{0, 0, 1, 5'd0, 8'd0, 0, 0, 1, 1};  // STOP at terminal count
    tbl[18] = '{0, 0, 0, 5'd0, 8'd0, 0, 0, 0, 1};  // no extra period
    tbl[19] = '{0, 1, 0, 5'd3, 8'd0, 0, 1, 0, 0};
    tbl[20] = '{0, 0, 0, 5'd0, 8'd0, 0, 1, 0, 0};
    tbl[21] = '{0, 0, 0, 5'd0, 8'd0, 0, 1, 0, 0};
    tbl[22] = '{0, 0, 0, 5'd0, 8'd0, 0, 1, 0, 0};
    tbl[23] = '{0, 0, 0, 5'd0, 8'd0, 1, 1, 0, 0};
    tbl[24] = '{1, 0, 0, 5'd0, 8'd0, 0, 0, 0, 0};  // reset mid-run with OUT=1
    tbl[25] = '{0, 0, 0, 5'd0, 8'd0, 0, 0, 0, 0};  // no DONE from reset

    for (int i = 0; i < 26; i++) begin
      step(tbl[i].rst, tbl[i].st, tbl[i].sp, tbl[i].div, tbl[i].nc);
      check($sformatf("tbl_out[%0d]", i),  64'(OUT),     64'(tbl[i].e_out));
      check($sformatf("tbl_busy[%0d]", i), 64'(BUSY),    64'(tbl[i].e_busy));
      check($sformatf("tbl_done[%0d]", i), 64'(DONE),    64'(tbl[i].e_done));
      check($sformatf("tbl_cyc[%0d]", i),  64'(CYC_CNT), 64'(tbl[i].e_cyc));
    end

    // DIV_SEL=3, NCYC=2: OUT high over E0+4..8 and E0+12..16, DONE after E0+16.
    step(1, 0, 0, 5'd0, 8'd0);
    step(0, 1, 0, 5'd3, 8'd2);
    done_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      step(0, 0, 0, 5'd0, 8'd0);
      out_h[i] = OUT; done_h[i] = DONE;
      if (DONE) done_cnt++;
    end
    check("t1_out_e3",  64'(out_h[3]),  64'd0);
    check("t1_out_e4",  64'(out_h[4]),  64'd1);
    check("t1_out_e7",  64'(out_h[7]),  64'd1);
    check("t1_out_e8",  64'(out_h[8]),  64'd0);
    check("t1_out_e12", 64'(out_h[12]), 64'd1);
    check("t1_out_e16", 64'(out_h[16]), 64'd0);
    check("t1_done_e16", 64'(done_h[16]), 64'd1);
    check("t1_done_cnt", 64'(done_cnt), 64'd1);
    check("t1_busy", 64'(BUSY), 64'd0);
    check("t1_cyc",  64'(CYC_CNT), 64'd2);

    // DIV_SEL=4 continuous, STOP while count=5 of the third period.
    step(1, 0, 0, 5'd0, 8'd0);
    step(0, 1, 0, 5'd4, 8'd0);
    end_at = -1; done_cnt = 0;
    for (int i = 1; i <= 60; i++) begin
      step(0, 0, (i == 38), 5'd0, 8'd0);
      out_h[i] = OUT;
      if (DONE) begin
        done_cnt++;
        if (end_at < 0) end_at = i;
      end
    end
    check("t2_end_edge", 64'(end_at), 64'd48);
    check("t2_out_e47",  64'(out_h[47]), 64'd1);
    check("t2_out_e48",  64'(out_h[48]), 64'd0);
    check("t2_done_cnt", 64'(done_cnt), 64'd1);
    check("t2_cyc",      64'(CYC_CNT), 64'd3);

    // DIV_SEL=0 -> period 2.
    step(1, 0, 0, 5'd0, 8'd0);
    step(0, 1, 0, 5'd0, 8'd0);
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, 0, 5'd0, 8'd0);
      check($sformatf("t3_alt[%0d]", i), 64'(OUT), 64'(i % 2));
    end

    // DIV_SEL=31 clamps to CNT_W -> period 2^CNT_W.
    step(1, 0, 0, 5'd0, 8'd0);
    step(0, 1, 0, 5'd31, 8'd1);
    end_at = -1;
    for (int i = 1; i <= 4200; i++) begin
      step(0, 0, 0, 5'd0, 8'd0);
      out_h[i] = OUT;
      if (DONE && end_at < 0) end_at = i;
    end
    check("t3_out_half_m1", 64'(out_h[2047]), 64'd0);
    check("t3_out_half",    64'(out_h[2048]), 64'd1);
    check("t3_out_last",    64'(out_h[4095]), 64'd1);
    check("t3_end_edge",    64'(end_at), 64'd4096);

    // START held with new DIV_SEL while busy; a new run starts after DONE.
    step(1, 0, 0, 5'd0, 8'd0);
    step(0, 1, 0, 5'd2, 8'd1);
    for (int i = 1; i <= 10; i++) begin
      step(0, 1, 0, 5'd5, 8'd1);
      out_h[i] = OUT; done_h[i] = DONE; busy_h[i] = BUSY;
    end
    check("t5_out_e2",  64'(out_h[2]),  64'd1);
    check("t5_done_e4", 64'(done_h[4]), 64'd1);
    check("t5_busy_e4", 64'(busy_h[4]), 64'd0);
    check("t5_busy_e5", 64'(busy_h[5]), 64'd1);
    check("t5_out_e7",  64'(out_h[7]),  64'd0);

    // Randomized traffic against the model.
    step(1, 0, 0, 5'd0, 8'd0);
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] r_div;
      r_div = ($urandom_range(0, 199) == 0) ? 5'($urandom_range(13, 31))
                                            : 5'($urandom_range(0, 4));
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 15) == 0),
           r_div,
           8'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
